// File: rtl/a3_bus_pkg.sv
// Shared definitions for the A3 CPU domain byte bus.
//   A3_ADDR_W / A3_DATA_W : bus address and data widths
//   busmem_state_t        : bus_mem responder FSM states
//   A3_OPEN_BUS           : value returned by reads of unmapped addresses
package a3_bus_pkg;

    localparam int A3_ADDR_W = 17;
    localparam int A3_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } busmem_state_t;

    localparam logic [A3_DATA_W-1:0] A3_OPEN_BUS = 8'hFF;

endpackage

// File: rtl/bus_mem_array.sv
// Single-port synchronous byte RAM, read-first, no reset (inference target).
//   clk   : clock
//   we    : write enable for this edge
//   addr  : array index
//   wdata : write data
//   rdata : registered read data (contents before any same-edge write)
module bus_mem_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_mem.sv
// Byte-wide memory responder for the A3 17-bit address bus.
// Accepts single-byte read/write requests, inserts WAIT_STATES wait cycles,
// performs the access on bus_mem_array and returns a one-cycle bus_ready.
// Unmapped accesses and overruns raise a one-cycle bus_err.
// Optional feature macro: A3_BUSMEM_WP_EN (write-protect addresses <= WP_TOP).
//   clk       : system clock
//   reset     : synchronous, active-high
//   bus_req   : single-cycle request strobe
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : byte address
//   bus_wdata : write data
//   bus_rdata : read data, valid while bus_ready
//   bus_ready : one-cycle completion strobe
//   bus_err   : one-cycle error strobe
//   bus_busy  : high whenever the FSM is not IDLE
module bus_mem
    import a3_bus_pkg::*;
#(
    parameter int                   MEM_DEPTH   = 4096,
    parameter int                   WAIT_STATES = 0,
    parameter logic [A3_ADDR_W-1:0] WP_TOP      = 17'h000FF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bus_req,
    input  logic                 bus_we,
    input  logic [A3_ADDR_W-1:0] bus_addr,
    input  logic [A3_DATA_W-1:0] bus_wdata,
    output logic [A3_DATA_W-1:0] bus_rdata,
    output logic                 bus_ready,
    output logic                 bus_err,
    output logic                 bus_busy
);

    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int CNT_W = 4;

    busmem_state_t        state;
    logic [CNT_W-1:0]     wait_cnt;

    // Request capture (data only, no reset)
    logic [A3_ADDR_W-1:0] addr_p0;
    logic                 we_p0;
    logic [A3_DATA_W-1:0] wdata_p0;

    // Response registers
    logic [A3_DATA_W-1:0] rdata_p1;
    logic                 rsel_p1;

    logic                 mapped;
    logic                 wp_hit;
    logic                 ram_we;
    logic [A3_DATA_W-1:0] ram_rdata;

    assign mapped = (addr_p0 < A3_ADDR_W'(MEM_DEPTH));

`ifdef A3_BUSMEM_WP_EN
    assign wp_hit = we_p0 && mapped && (addr_p0 <= WP_TOP);
`else
    assign wp_hit = 1'b0;
    logic unused_wp_top;
    assign unused_wp_top = ^WP_TOP;
`endif

    // A write abandoned by reset at its own ACCESS edge must not land.
    assign ram_we = (state == ACCESS) && we_p0 && mapped && !wp_hit && !reset;

    bus_mem_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW),
        .DW    (A3_DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_p0[AW-1:0]),
        .wdata (wdata_p0),
        .rdata (ram_rdata)
    );

    // Stage p0: latch the request on the accepting edge
    always_ff @(posedge clk) begin
        if (!reset && (state == IDLE) && bus_req) begin
            addr_p0  <= bus_addr;
            we_p0    <= bus_we;
            wdata_p0 <= bus_wdata;
        end
    end

    // FSM and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            bus_ready <= 1'b0;
            bus_err   <= 1'b0;
            bus_busy  <= 1'b0;
            rdata_p1  <= '0;
            rsel_p1   <= 1'b0;
        end else begin
            bus_ready <= 1'b0;
            // Overrun: a request while busy is dropped and flagged.
            bus_err   <= bus_req && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus_req) begin
                        bus_busy <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= CNT_W'(WAIT_STATES);
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt <= CNT_W'(1)) begin
                        state    <= ACCESS;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ACCESS: begin
                    // Stage p1: RAM read issued this edge; result shown in RESP
                    state     <= RESP;
                    bus_ready <= 1'b1;
                    if (!mapped || wp_hit) begin
                        bus_err <= 1'b1;
                    end
                    rsel_p1  <= mapped && !we_p0;
                    rdata_p1 <= (!mapped && !we_p0) ? A3_OPEN_BUS : '0;
                end
                RESP: begin
                    state    <= IDLE;
                    bus_busy <= 1'b0;
                    rsel_p1  <= 1'b0;
                    rdata_p1 <= '0;
                end
                default: begin
                    state    <= IDLE;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

    // Mapped read data comes straight from the RAM output register.
    assign bus_rdata = rsel_p1 ? ram_rdata : rdata_p1;

endmodule

// File: tb/tb_bus_mem.sv
// Directed self-checking bench for bus_mem: one instance with no wait
// states and one with three wait states, both with MEM_DEPTH = 4096.
module tb_bus_mem;

    logic        clk;
    logic        reset;
    logic        req   [2];
    logic        we    [2];
    logic [16:0] addr  [2];
    logic [7:0]  wdata [2];
    logic [7:0]  rdata [2];
    logic        ready [2];
    logic        err   [2];
    logic        busy  [2];

    int n_asserts = 0;
    int n_fail    = 0;

    bus_mem #(.MEM_DEPTH(4096), .WAIT_STATES(0), .WP_TOP(17'h000FF)) dut0 (
        .clk(clk), .reset(reset), .bus_req(req[0]), .bus_we(we[0]),
        .bus_addr(addr[0]), .bus_wdata(wdata[0]), .bus_rdata(rdata[0]),
        .bus_ready(ready[0]), .bus_err(err[0]), .bus_busy(busy[0])
    );

    bus_mem #(.MEM_DEPTH(4096), .WAIT_STATES(3), .WP_TOP(17'h000FF)) dut3 (
        .clk(clk), .reset(reset), .bus_req(req[1]), .bus_we(we[1]),
        .bus_addr(addr[1]), .bus_wdata(wdata[1]), .bus_rdata(rdata[1]),
        .bus_ready(ready[1]), .bus_err(err[1]), .bus_busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transaction on unit u. lat counts edges from the
    // accepting edge (1) to the edge after which bus_ready is seen.
    task automatic txn(input int u, input logic w, input logic [16:0] a,
                       input logic [7:0] d, output logic [7:0] rd,
                       output logic er, output int lat);
        @(negedge clk);
        req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
        @(posedge clk); #1;
        req[u] = 1'b0;
        lat = 1;
        check("busy_after_accept", 32'(busy[u]), 32'd1);
        while (!ready[u] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) check("ready_timeout", 32'(lat), 32'd0);
        rd = rdata[u];
        er = err[u];
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(ready[u]), 32'd0);
        check("busy_back_idle", 32'(busy[u]), 32'd0);
    endtask

    logic [7:0] rd;
    logic       er;
    int         lat;
    int         nready;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready[0]), 32'd0);
        check("rst_err",   32'(err[0]),   32'd0);
        check("rst_busy",  32'(busy[0]),  32'd0);
        check("rst_rdata", 32'(rdata[0]), 32'h00);
        check("rst_busy3", 32'(busy[1]),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic write then read, no wait states
        txn(0, 1'b1, 17'h00123, 8'hA5, rd, er, lat);
        check("wr_lat", 32'(lat), 32'd2);
        check("wr_err", 32'(er), 32'd0);
        check("wr_rdata", 32'(rd), 32'h00);
        txn(0, 1'b0, 17'h00123, 8'h00, rd, er, lat);
        check("rd_lat", 32'(lat), 32'd2);
        check("rd_data", 32'(rd), 32'hA5);
        check("rd_err", 32'(er), 32'd0);

        // Unmapped read and no aliasing of 0x01000 onto 0x00000
        txn(0, 1'b0, 17'h1F000, 8'h00, rd, er, lat);
        check("unmap_rd_data", 32'(rd), 32'hFF);
        check("unmap_rd_err", 32'(er), 32'd1);
        check("unmap_rd_lat", 32'(lat), 32'd2);
        txn(0, 1'b1, 17'h00000, 8'h5A, rd, er, lat);
        txn(0, 1'b1, 17'h01000, 8'h11, rd, er, lat);
        check("unmap_wr_err", 32'(er), 32'd1);
        txn(0, 1'b0, 17'h00000, 8'h00, rd, er, lat);
        check("no_alias", 32'(rd), 32'h5A);

        // Overrun coinciding with RESP on the zero-wait unit: single pulse
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 17'h00123;
        @(posedge clk); #1;
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; wdata[0] = 8'h00;
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("coinc_ready", 32'(ready[0]), 32'd1);
        check("coinc_err", 32'(err[0]), 32'd1);
        check("coinc_data", 32'(rdata[0]), 32'hA5);
        @(posedge clk); #1;
        check("coinc_err_single", 32'(err[0]), 32'd0);
        check("coinc_ready_single", 32'(ready[0]), 32'd0);

        // Three wait states
        txn(1, 1'b1, 17'h00200, 8'h3C, rd, er, lat);
        check("ws3_wr_lat", 32'(lat), 32'd5);
        txn(1, 1'b0, 17'h00200, 8'h00, rd, er, lat);
        check("ws3_rd_lat", 32'(lat), 32'd5);
        check("ws3_rd_data", 32'(rd), 32'h3C);
        check("ws3_rd_err", 32'(er), 32'd0);

        // Overrun during WAIT: error without ready, first transaction intact
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 17'h00200;
        @(posedge clk); #1;
        lat = 1;
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; wdata[1] = 8'h55;
        @(posedge clk); #1;
        req[1] = 1'b0;
        lat++;
        check("ovr_err", 32'(err[1]), 32'd1);
        check("ovr_no_ready", 32'(ready[1]), 32'd0);
        nready = 0;
        while (!ready[1] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (ready[1]) nready++;
        check("ovr_lat", 32'(lat), 32'd5);
        check("ovr_data", 32'(rdata[1]), 32'h3C);
        check("ovr_resp_err", 32'(err[1]), 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            if (ready[1]) nready++;
        end
        check("ovr_one_ready", 32'(nready), 32'd1);
        txn(1, 1'b0, 17'h00200, 8'h00, rd, er, lat);
        check("ovr_wr_dropped", 32'(rd), 32'h3C);

        // Reset during WAIT of a write
        txn(1, 1'b1, 17'h00010, 8'h42, rd, er, lat);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 17'h00010; wdata[1] = 8'h99;
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ready", 32'(ready[1]), 32'd0);
        check("mid_rst_err", 32'(err[1]), 32'd0);
        check("mid_rst_busy", 32'(busy[1]), 32'd0);
        check("mid_rst_rdata", 32'(rdata[1]), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        txn(1, 1'b0, 17'h00010, 8'h00, rd, er, lat);
        check("mid_rst_no_write", 32'(rd), 32'h42);

        // Write into the protectable region
`ifdef A3_BUSMEM_WP_EN
        begin
            logic [7:0] before;
            txn(0, 1'b0, 17'h00080, 8'h00, before, er, lat);
            txn(0, 1'b1, 17'h00080, 8'h77, rd, er, lat);
            check("wp_err", 32'(er), 32'd1);
            check("wp_lat", 32'(lat), 32'd2);
            txn(0, 1'b0, 17'h00080, 8'h00, rd, er, lat);
            check("wp_readback", 32'(rd), 32'(before));
            check("wp_rd_err", 32'(er), 32'd0);
        end
`else
        txn(0, 1'b1, 17'h00080, 8'h77, rd, er, lat);
        check("nowp_err", 32'(er), 32'd0);
        txn(0, 1'b0, 17'h00080, 8'h00, rd, er, lat);
        check("nowp_readback", 32'(rd), 32'h77);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
